tft_touch_reader: RTL and testbench

- SPI master for the resistive-touch controller on the TFT module: XPT2046-compatible, 12-bit, differential mode.
- Waits for pen-down on T_IRQ, then polls X and Y periodically as two 24-clock conversion frames.
- Presents the latest coordinate pair to the system bus side with a one-cycle valid strobe.
- Sits between the tftT_* pads and the system_2MB peripheral/port logic.

---
 rtl/tft_touch_pkg.sv | 29 ++
 rtl/spi_frame24.sv | 92 +++++++++
 rtl/tft_touch_reader.sv | 137 +++++++++++++
 tb/tb_tft_touch_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_touch_pkg.sv
// Shared constants and state encodings for the XPT2046-compatible touch reader.
`timescale 1ns/1ps
package tft_touch_pkg;

  // Start bit, 12-bit mode, differential reference, PD=00 so PENIRQ stays armed.
  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  // Clock indices within the 24-clock frame that carry conversion data, MSB first.
  localparam int FIRST_DATA_BIT = 9;
  localparam int LAST_DATA_BIT  = 20;
  localparam int LAST_BIT       = 23;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP,
    CHECK,
    WAIT
  } state_t;

  typedef enum logic {
    CH_X,
    CH_Y
  } chan_t;

endpackage

// File: rtl/spi_frame24.sv
// One CS-framed, 24-clock SPI transfer: 8 command bits out, 12 data bits captured.
`timescale 1ns/1ps
module spi_frame24
  import tft_touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic        sdo,
  output logic        done,
  output logic [11:0] rx,
  output logic        sclk,
  output logic        cs,
  output logic        din
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_t      state;
  logic [DW-1:0] div_cnt;
  logic [4:0]  bit_idx;
  logic        high_half;
  logic [7:0]  cmd_sh;
  logic        div_end;

  assign div_end = (div_cnt == DIV_LAST);

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      din       <= 1'b0;
      done      <= 1'b0;
      rx        <= '0;
      div_cnt   <= '0;
      bit_idx   <= '0;
      high_half <= 1'b0;
      cmd_sh    <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) div_cnt <= div_end ? '0 : div_cnt + DW'(1);
      case (state)
        IDLE: if (start) begin
          cs      <= 1'b0;
          sclk    <= 1'b0;
          din     <= cmd[7];
          cmd_sh  <= cmd;
          rx      <= '0;
          div_cnt <= '0;
          state   <= CS_SETUP;
        end
        CS_SETUP: if (div_end) begin
          bit_idx   <= '0;
          high_half <= 1'b0;
          state     <= SHIFT;
        end
        SHIFT: if (div_end) begin
          if (!high_half) begin
            high_half <= 1'b1;
            sclk      <= 1'b1;
          end else begin
            if (bit_idx >= 5'(FIRST_DATA_BIT) && bit_idx <= 5'(LAST_DATA_BIT))
              rx <= {rx[10:0], sdo};
            sclk      <= 1'b0;
            high_half <= 1'b0;
            if (bit_idx == 5'(LAST_BIT)) begin
              state <= CS_HOLD;
            end else begin
              // Zeros shift in behind the command, so din is 0 after bit 7.
              bit_idx <= bit_idx + 5'd1;
              cmd_sh  <= {cmd_sh[6:0], 1'b0};
              din     <= cmd_sh[6];
            end
          end
        end
        CS_HOLD: if (div_end) begin
          cs    <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tft_touch_reader.sv
// XPT2046 touch poller: waits for pen-down, reads X then Y, publishes the pair if the pen stayed down.
`timescale 1ns/1ps
module tft_touch_reader
  import tft_touch_pkg::*;
#(
  parameter int CLK_DIV     = 25,
  parameter int POLL_CYCLES = 500000,
  parameter int GAP_CYCLES  = 50
) (
  input  logic        CLK_50MHZ,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tft_t_irq,
  input  logic        tft_t_do,
  output logic        tft_t_clk,
  output logic        tft_t_cs,
  output logic        tft_t_din,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        valid,
  output logic        pen_down,
  output logic        busy
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);

  logic [1:0]    irq_ff, do_ff;
  logic          irq_sync;
  state_t        state;
  chan_t         ch;
  logic          start, done;
  logic [7:0]    cmd;
  logic [11:0]   rx, x_tmp;
  logic [PW-1:0] poll_cnt;
  logic [GW-1:0] gap_cnt;

  assign irq_sync = irq_ff[1];

  // NOTE: PENIRQ resets to its idle-high level so reset never reads as a pen touch.
  always_ff @(posedge CLK_50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      irq_ff <= 2'b11;
      do_ff  <= 2'b00;
    end else begin
      irq_ff <= {irq_ff[0], tft_t_irq};
      do_ff  <= {do_ff[0], tft_t_do};
    end
  end

  spi_frame24 #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk   (CLK_50MHZ),
    .rst_n (rst_n),
    .start (start),
    .cmd   (cmd),
    .sdo   (do_ff[1]),
    .done  (done),
    .rx    (rx),
    .sclk  (tft_t_clk),
    .cs    (tft_t_cs),
    .din   (tft_t_din)
  );

  // CS_SETUP here covers the whole frame on the wire; the sub-module tracks its phases.
  always_ff @(posedge CLK_50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch       <= CH_X;
      start    <= 1'b0;
      cmd      <= '0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      x_tmp    <= '0;
      x        <= '0;
      y        <= '0;
      valid    <= 1'b0;
      pen_down <= 1'b0;
      busy     <= 1'b0;
    end else begin
      start <= 1'b0;
      valid <= 1'b0;
      if (poll_cnt != '0) poll_cnt <= poll_cnt - PW'(1);
      case (state)
        IDLE, WAIT: begin
          pen_down <= ~irq_sync;
          // An expired poll timer behaves as IDLE in the same cycle.
          if (state == IDLE || poll_cnt == '0) begin
            if (enable && pen_down) begin
              start    <= 1'b1;
              cmd      <= CMD_X;
              ch       <= CH_X;
              poll_cnt <= POLL_LOAD;
              busy     <= 1'b1;
              state    <= CS_SETUP;
            end else begin
              state <= IDLE;
            end
          end
        end
        CS_SETUP: if (done) begin
          if (ch == CH_X) begin
            x_tmp   <= rx;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else begin
            state <= CHECK;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            start <= 1'b1;
            cmd   <= CMD_Y;
            ch    <= CH_Y;
            state <= CS_SETUP;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        CHECK: begin
          if (!irq_sync) begin
            x     <= x_tmp;
            y     <= rx;
            valid <= 1'b1;
          end else begin
            pen_down <= 1'b0;
          end
          busy  <= 1'b0;
          state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_touch_reader.sv
// Directed bench: an XPT2046 bus model answers each frame; coordinate pairs come from a vector table.
`timescale 1ns/1ps
module tb_tft_touch_reader;
  import tft_touch_pkg::*;

  localparam int CLK_DIV = 25;
  localparam int POLL    = 4000;
  localparam int GAPC    = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tft_t_irq = 1'b1;
  logic        tft_t_do = 1'b0;
  logic        tft_t_clk, tft_t_cs, tft_t_din;
  logic [11:0] x, y;
  logic        valid, pen_down, busy;

  always #10 clk = ~clk;

  tft_touch_reader #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL), .GAP_CYCLES(GAPC)) dut (
    .CLK_50MHZ (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .tft_t_irq (tft_t_irq),
    .tft_t_do  (tft_t_do),
    .tft_t_clk (tft_t_clk),
    .tft_t_cs  (tft_t_cs),
    .tft_t_din (tft_t_din),
    .x         (x),
    .y         (y),
    .valid     (valid),
    .pen_down  (pen_down),
    .busy      (busy)
  );

  // Touch controller model and bus monitor, sampled on the falling system-clock edge.
  logic [11:0] mx = '0, my = '0;
  logic [11:0] word;
  logic [7:0]  cmd_rx = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  int cyc = 0, rise_cnt = 0, rise_total = 0, last_rise = 0;
  int per_cnt = 0, per_bad = 0, cs_fall_cnt = 0, frame_cnt = 0, valid_cnt = 0;
  int fall_hist[64];
  int rises_hist[64];
  logic [7:0] cmd_hist[64];

  // NOTE: blocking assignments are right here; this process is the sole writer of its variables.
  always @(negedge clk) begin
    cyc++;
    if (valid) valid_cnt++;
    if (prev_cs && !tft_t_cs) begin
      fall_hist[cs_fall_cnt % 64] = cyc;
      cs_fall_cnt++;
      rise_cnt = 0;
      cmd_rx   = '0;
    end
    if (!prev_cs && tft_t_cs) begin
      cmd_hist[frame_cnt % 64]   = cmd_rx;
      rises_hist[frame_cnt % 64] = rise_cnt;
      frame_cnt++;
    end
    if (!prev_sclk && tft_t_clk) begin
      rise_total++;
      if (!tft_t_cs) begin
        if (rise_cnt < 8) cmd_rx = {cmd_rx[6:0], tft_t_din};
        if (rise_cnt > 0) begin
          per_cnt++;
          if (cyc - last_rise != 2 * CLK_DIV) per_bad++;
        end
        last_rise = cyc;
        rise_cnt++;
      end
    end
    if (prev_sclk && !tft_t_clk && !tft_t_cs) begin
      if (rise_cnt >= 9 && rise_cnt <= 20) begin
        word     = (cmd_rx == CMD_X) ? mx : my;
        tft_t_do = word[20 - rise_cnt];
      end else begin
        tft_t_do = 1'b0;
      end
    end
    prev_cs   = tft_t_cs;
    prev_sclk = tft_t_clk;
  end

  typedef struct {
    logic [11:0] mx;
    logic [11:0] my;
    logic [11:0] exp_x;
    logic [11:0] exp_y;
  } vec_t;

  vec_t vecs[4];
  int   n_tests = 0, n_fail = 0;
  int   v0, c, fb, fc;
  bit   ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit hit);
    int start_cnt;
    start_cnt = valid_cnt;
    hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (valid_cnt != start_cnt) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    vecs[0] = '{12'hABC, 12'h123, 12'hABC, 12'h123};
    vecs[1] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
    vecs[2] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
    vecs[3] = '{12'h5A5, 12'hA5A, 12'h5A5, 12'hA5A};

    // Reset held with PENIRQ toggling.
    for (int i = 0; i < 10; i++) begin
      tick();
      tft_t_irq = ~tft_t_irq;
    end
    check("rst_cs", tft_t_cs, 1);
    check("rst_sclk", tft_t_clk, 0);
    check("rst_din", tft_t_din, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_valid", valid, 0);
    check("rst_pen_down", pen_down, 0);
    check("rst_busy", busy, 0);
    check("rst_no_sclk_edges", rise_total, 0);

    // Pen up with polling enabled.
    tft_t_irq = 1'b1;
    enable    = 1'b1;
    rst_n     = 1'b1;
    repeat (5000) tick();
    check("penup_no_cs", cs_fall_cnt, 0);
    check("penup_no_valid", valid_cnt, 0);
    check("penup_pen_down", pen_down, 0);
    check("penup_busy", busy, 0);

    // Pen held down, one pair per table row.
    fb = cs_fall_cnt;
    tft_t_irq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mx = vecs[i].mx;
      my = vecs[i].my;
      v0 = valid_cnt;
      wait_valid(3 * POLL, ok);
      check($sformatf("pair%0d_valid_seen", i), ok, 1);
      check($sformatf("pair%0d_x", i), x, vecs[i].exp_x);
      check($sformatf("pair%0d_y", i), y, vecs[i].exp_y);
      check($sformatf("pair%0d_pen_down", i), pen_down, 1);
      check($sformatf("pair%0d_busy_after", i), busy, 0);
      repeat (3) tick();
      check($sformatf("pair%0d_one_pulse", i), valid_cnt - v0, 1);
      check($sformatf("pair%0d_cmd_x", i), cmd_hist[(frame_cnt - 2) % 64], CMD_X);
      check($sformatf("pair%0d_cmd_y", i), cmd_hist[(frame_cnt - 1) % 64], CMD_Y);
      check($sformatf("pair%0d_rises_x", i), rises_hist[(frame_cnt - 2) % 64], 24);
      check($sformatf("pair%0d_rises_y", i), rises_hist[(frame_cnt - 1) % 64], 24);
    end
    check("poll_interval_1", fall_hist[(fb + 2) % 64] - fall_hist[fb % 64], POLL);
    check("poll_interval_2", fall_hist[(fb + 4) % 64] - fall_hist[(fb + 2) % 64], POLL);
    check("sclk_periods_measured", per_cnt >= 23 * 8, 1);
    check("sclk_period_bad", per_bad, 0);

    // Pen released during the Y frame: the pair is discarded.
    mx = 12'h111;
    my = 12'h222;
    c  = cs_fall_cnt;
    v0 = valid_cnt;
    ok = 1'b0;
    for (int k = 0; k < 2 * POLL; k++) begin
      tick();
      if (cs_fall_cnt >= c + 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("rel_y_frame_seen", ok, 1);
    repeat (100) tick();
    tft_t_irq = 1'b1;
    repeat (20) tick();
    check("rel_pen_held_in_frame", pen_down, 1);
    fc = frame_cnt;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (frame_cnt > fc) begin
        ok = 1'b1;
        break;
      end
    end
    check("rel_y_frame_end", ok, 1);
    repeat (20) tick();
    check("rel_no_valid", valid_cnt - v0, 0);
    check("rel_x_kept", x, vecs[3].exp_x);
    check("rel_y_kept", y, vecs[3].exp_y);
    check("rel_pen_down", pen_down, 0);

    // Reset pulsed at bit 12 of an X frame, then a clean restart.
    mx = 12'h345;
    my = 12'h678;
    tft_t_irq = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 2 * POLL; k++) begin
      tick();
      if (!tft_t_cs && rise_cnt == 12 && cmd_rx == CMD_X) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_x_bit12_seen", ok, 1);
    check("mid_busy", busy, 1);
    v0 = valid_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs_async", tft_t_cs, 1);
    check("mid_rst_sclk", tft_t_clk, 0);
    repeat (3) tick();
    check("mid_rst_x", x, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_no_valid", valid_cnt - v0, 0);
    rst_n = 1'b1;
    wait_valid(3 * POLL, ok);
    check("restart_valid_seen", ok, 1);
    check("restart_x", x, 12'h345);
    check("restart_y", y, 12'h678);

    // Enable dropped during the X frame: the pair finishes, then polling stops.
    mx = 12'h9AB;
    my = 12'hCDE;
    c  = cs_fall_cnt;
    ok = 1'b0;
    for (int k = 0; k < 2 * POLL; k++) begin
      tick();
      if (cs_fall_cnt > c && !tft_t_cs && rise_cnt == 5) begin
        ok = 1'b1;
        break;
      end
    end
    check("dis_x_frame_seen", ok, 1);
    enable = 1'b0;
    v0 = valid_cnt;
    wait_valid(POLL, ok);
    check("dis_valid_seen", ok, 1);
    check("dis_x", x, 12'h9AB);
    check("dis_y", y, 12'hCDE);
    repeat (3) tick();
    check("dis_one_pulse", valid_cnt - v0, 1);
    c  = cs_fall_cnt;
    v0 = valid_cnt;
    repeat (8000) tick();
    check("dis_no_new_frame", cs_fall_cnt - c, 0);
    check("dis_no_new_valid", valid_cnt - v0, 0);
    check("dis_cs_high", tft_t_cs, 1);
    check("dis_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
